// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared types and constants for the RTC bus sequencer
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD
  } state_t;

  localparam int SWEEP_LEN = 11;

  // Entry 0 is the first register swept.
  localparam logic [SWEEP_LEN-1:0][7:0] SWEEP_ADDRS = {
    8'h43, 8'h42, 8'h41, 8'h28, 8'h27, 8'h26,
    8'h25, 8'h24, 8'h23, 8'h22, 8'h21
  };

  localparam logic AOD_ADDR = 1'b1;
  localparam logic AOD_DATA = 1'b0;

  function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
    return (idx < 4'(SWEEP_LEN)) ? SWEEP_ADDRS[idx] : SWEEP_ADDRS[0];
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// rtl/rtc_bus_sequencer_timer.sv - per-state phase down-counter
module rtc_phase_timer #(
  parameter int PHASE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic last_cycle,
  output logic near_last
);

  localparam int CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PHASE_CYCLES - 1);

  logic [CW-1:0] count;

  // Reload at every state change, otherwise count down to zero and park there.
  always_ff @(posedge clk) begin
    if (!reset_n || load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign last_cycle = (count == '0);
  assign near_last  = (count == CW'(1));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - RTC multiplexed bus sweep/write sequencer
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter bit AUTO_SWEEP   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sweep_req,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       busy,
  output logic       sweep_done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       aod,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic [7:0] bank_addr,
  output logic [7:0] bank_data,
  output logic       bank_aod
);

  state_t     state;
  logic       is_wr;
  logic [7:0] cur_addr;
  logic [7:0] cur_wdata;
  logic [3:0] sweep_idx;
  logic       sweep_active;
  logic       last_cycle;
  logic       near_last;
  logic       load;

  assign load = (state == ST_IDLE) || last_cycle;

  rtc_phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .last_cycle (last_cycle),
    .near_last  (near_last)
  );

  // Transaction FSM; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      is_wr        <= 1'b0;
      cur_addr     <= 8'h00;
      cur_wdata    <= 8'h00;
      sweep_idx    <= 4'd0;
      sweep_active <= 1'b0;
      cs_n         <= 1'b1;
      rd_n         <= 1'b1;
      wr_n         <= 1'b1;
      aod          <= AOD_ADDR;
      ad_oe        <= 1'b0;
      ad_out       <= 8'h00;
      bank_aod     <= AOD_ADDR;
      bank_addr    <= 8'h00;
      bank_data    <= 8'h00;
      busy         <= 1'b0;
      wr_ack       <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      wr_ack     <= 1'b0;
      sweep_done <= 1'b0;
      bank_aod   <= AOD_ADDR;
      case (state)
        ST_IDLE: begin
          if (sweep_req) sweep_active <= 1'b1;
          if (wr_req) begin
            // Writes win; a sweep requested in the same cycle is remembered.
            is_wr     <= 1'b1;
            cur_addr  <= wr_addr;
            cur_wdata <= wr_data;
            ad_out    <= wr_addr;
            state     <= ST_A_SETUP;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            aod       <= AOD_ADDR;
            ad_oe     <= 1'b1;
          end else if (sweep_active || sweep_req || AUTO_SWEEP) begin
            is_wr     <= 1'b0;
            cur_addr  <= sweep_addr(sweep_idx);
            ad_out    <= sweep_addr(sweep_idx);
            state     <= ST_A_SETUP;
            busy      <= 1'b1;
            cs_n      <= 1'b0;
            aod       <= AOD_ADDR;
            ad_oe     <= 1'b1;
          end
        end
        ST_A_SETUP: if (last_cycle) begin
          state <= ST_A_STROBE;
          wr_n  <= 1'b0;
        end
        ST_A_STROBE: if (last_cycle) begin
          state <= ST_A_HOLD;
          wr_n  <= 1'b1;
        end
        ST_A_HOLD: if (last_cycle) begin
          state  <= ST_D_SETUP;
          aod    <= AOD_DATA;
          ad_oe  <= is_wr;
          ad_out <= is_wr ? cur_wdata : 8'h00;
        end
        ST_D_SETUP: if (last_cycle) begin
          state <= ST_D_STROBE;
          if (is_wr) wr_n <= 1'b0;
          else       rd_n <= 1'b0;
        end
        ST_D_STROBE: if (last_cycle) begin
          state <= ST_D_HOLD;
          wr_n  <= 1'b1;
          rd_n  <= 1'b1;
          if (!is_wr) begin
            // Sample the chip on the final strobe clock and hand it to the bank.
            bank_aod  <= AOD_DATA;
            bank_addr <= cur_addr;
            bank_data <= ad_in;
          end else if (PHASE_CYCLES == 1) begin
            wr_ack <= 1'b1;
          end
        end
        ST_D_HOLD: begin
          if (is_wr && near_last) wr_ack <= 1'b1;
          if (last_cycle) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            cs_n   <= 1'b1;
            aod    <= AOD_ADDR;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
            if (!is_wr) begin
              if (sweep_idx == 4'(SWEEP_LEN - 1)) begin
                sweep_idx    <= 4'd0;
                sweep_active <= 1'b0;
                sweep_done   <= 1'b1;
              end else begin
                sweep_idx <= sweep_idx + 4'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequences the multiplexed address/data bus of the real-time-clock chip and feeds the time/date register bank. It sweeps eleven RTC registers (0x21–0x28, 0x41–0x43) with one read transaction each, then presents every byte to the register bank as a one-cycle address/data/AoD strobe. It also arbitrates single-byte write requests from the time-setting logic into the gaps between transactions. It sits between the RTC pins and the register bank feeding the VGA path.

## Interface
- PHASE_CYCLES, 4, clocks per bus phase, ≥1
- AUTO_SWEEP, 1, 1: start a new sweep whenever idle; 0: sweep only on sweep_req
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- sweep_req  in  1  one-cycle pulse, start a sweep (ignored while busy)
- wr_req  in  1  level, held until wr_ack
- wr_addr  in  8  RTC register to write
- wr_data  in  8  byte to write
- wr_ack  out  1  one-cycle pulse, write transaction finished
- busy  out  1  transaction in progress
- sweep_done  out  1  one-cycle pulse after the 11th read
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active low
- aod  out  1  RTC bus phase, 1 = address, 0 = data
- ad_out  out  8  bus drive value
- ad_oe  out  1  bus output enable
- ad_in  in  8  bus sample
- bank_addr  out  8  register-bank address
- bank_data  out  8  register-bank data
- bank_aod  out  1  register-bank AoD; bank captures when 0

## Operation
- FSM: IDLE → A_SETUP → A_STROBE → A_HOLD → D_SETUP → D_STROBE → D_HOLD → IDLE. Every non-IDLE state lasts exactly PHASE_CYCLES clocks.
- IDLE arbitration, one cycle:
  - wr_req has priority → write transaction.
  - Otherwise, if a sweep is active or being started (sweep_req, or AUTO_SWEEP=1) → read at sweep_idx.
  - Otherwise stay in IDLE.
- A transaction is never interrupted. A write pending during a sweep is inserted before the next sweep read. The sweep resumes at the same sweep_idx.
- Sweep order, sweep_idx 0..10: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x27, 0x28, 0x41, 0x42, 0x43. sweep_idx increments after each read D_HOLD. After index 10 it wraps to 0 and sweep_done pulses.
- Address phases:
  - cs_n=0 from A_SETUP through D_HOLD; otherwise 1.
  - aod=1 and ad_oe=1 with ad_out = address in A_SETUP, A_STROBE, A_HOLD.
  - wr_n=0 during A_STROBE only (address latch).
- Read data phase:
  - aod=0 from D_SETUP; ad_oe=0 from D_SETUP.
  - rd_n=0 in D_STROBE.
  - ad_in is sampled on the last clock of D_STROBE.
- Write data phase:
  - aod=0; ad_oe=1 with ad_out = wr_data (latched at arbitration) through D_HOLD.
  - wr_n=0 in D_STROBE.
  - wr_ack pulses in the last cycle of D_HOLD.
- Bank port:
  - bank_aod=1 at all times except one cycle, the first cycle of D_HOLD of a read.
  - In that cycle bank_addr = swept address and bank_data = sampled byte.
  - bank_addr and bank_data hold their values otherwise.
  - Writes never strobe the bank.
- busy=1 in every non-IDLE state.

## Timing
- Transaction: 6·PHASE_CYCLES clocks + 1 IDLE clock. Full sweep with no writes: 11·(6·PHASE_CYCLES+1).
- All outputs registered; strobe edges coincide with state changes.
- Reset values:
  - cs_n = rd_n = wr_n = aod = bank_aod = 1
  - ad_oe = 0, ad_out = 0, bank_addr = 0, bank_data = 0
  - busy = 0, wr_ack = 0, sweep_done = 0
  - sweep_idx = 0, FSM = IDLE
- Reset mid-transaction: idle values on the next edge. The sweep restarts from 0x21. A pending write is retried only if wr_req is still high.
- sweep_req while busy is ignored. wr_req and sweep_req in the same IDLE cycle: the write goes first, and the sweep starts in the next IDLE.
- PHASE_CYCLES=1: each state lasts exactly one clock.

## Structure
- Package rtc_bus_pkg holds:
  - state enum
  - SWEEP_LEN=11 and the sweep address array
  - address/data phase constants (AOD_ADDR=1, AOD_DATA=0)
- One sub-module, rtc_phase_timer: loadable down-counter of width $clog2(PHASE_CYCLES+1); asserts last_cycle, reloads on state change.

## Test plan
- AUTO_SWEEP=0, PHASE_CYCLES=4, RTC model returning address XOR 0xA5, one sweep_req → 11 reads in order 0x21..0x43; bank_aod low exactly 11 times; bank_data=0x84 at 0x21 and 0xE6 at 0x43; sweep_done one pulse 11·25 cycles after start.
- Bus waveform check on one read → cs_n low 24 cycles; wr_n low only in cycles 5–8; rd_n low in cycles 17–20; ad_oe=0 in cycles 13–24.
- wr_req(0x22, 0x59) raised during read of 0x24 → read completes; write transaction precedes the read of 0x25; wr_ack once; no bank strobe for the write.
- Simultaneous wr_req and sweep_req in IDLE → write first, then sweep starting at 0x21.
- reset_n low mid-D_STROBE for one cycle → next cycle all outputs at reset values; next sweep begins at 0x21.
- PHASE_CYCLES=1, AUTO_SWEEP=1 → back-to-back sweeps every 77 cycles; sweep_idx wraps 10→0 cleanly.
